// File: rtl/mem_lsu.sv
// Load/store stage: decodes memory ops, drives dmem, aligns store data, extends load data,
// traps misaligned/out-of-range accesses and holds a registered MEM/WB result with backpressure.
module mem_lsu #(
    parameter logic [31:0] DATA_BEGIN = 32'h1001_0000,
    parameter logic [31:0] DATA_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_badaddr,
    input  logic        exc_ack
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic {RUN, EXC} state_t;
    state_t state;

    logic        is_load, is_store;
    logic        sz_byte, sz_half, sz_word;
    logic        in_range, misalign, fault, run, accept;
    logic [32:0] data_end;
    logic [31:0] lane, load_data;
    logic [3:0]  sel_raw;
    logic [31:0] wdata_raw;

    // Lane-shifted read word; byte/half extraction then only looks at the low bits.
    assign lane = mem_rdata >> {ex_addr[1:0], 3'b000};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        sz_byte   = 1'b0;
        sz_half   = 1'b0;
        sz_word   = 1'b0;
        load_data = lane;
        case (ex_op)
            OP_LB:  begin is_load = 1'b1; sz_byte = 1'b1; load_data = {{24{lane[7]}}, lane[7:0]}; end
            OP_LBU: begin is_load = 1'b1; sz_byte = 1'b1; load_data = {24'h0, lane[7:0]}; end
            OP_LH:  begin is_load = 1'b1; sz_half = 1'b1; load_data = {{16{lane[15]}}, lane[15:0]}; end
            OP_LHU: begin is_load = 1'b1; sz_half = 1'b1; load_data = {16'h0, lane[15:0]}; end
            OP_LW:  begin is_load = 1'b1; sz_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    // Range check carried in 33 bits so a segment ending at 4 GiB does not wrap.
    assign data_end = {1'b0, DATA_BEGIN} + {1'b0, DATA_BYTES};
    assign in_range = ({1'b0, ex_addr} >= {1'b0, DATA_BEGIN}) && ({1'b0, ex_addr} < data_end);
    assign misalign = (sz_half & ex_addr[0]) | (sz_word & (|ex_addr[1:0]));
    assign fault    = (is_load | is_store) & (misalign | ~in_range);

    assign run      = (state == RUN);
    assign ex_ready = run ? (~wb_valid | wb_ready) : 1'b1;
    assign accept   = ex_valid & ex_ready;

    assign mem_ce   = accept & (is_load | is_store) & ~fault & run;
    assign mem_we   = mem_ce & is_store;
    assign mem_addr = ex_addr;

    always_comb begin
        sel_raw   = '0;
        wdata_raw = ex_sdata;
        if (sz_byte) begin
            sel_raw   = 4'b0001 << ex_addr[1:0];
            wdata_raw = {4{ex_sdata[7:0]}};
        end else if (sz_half) begin
            sel_raw   = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_raw = {2{ex_sdata[15:0]}};
        end else if (sz_word) begin
            sel_raw   = 4'b1111;
        end
    end

    assign mem_sel   = mem_ce ? sel_raw : '0;
    assign mem_wdata = mem_we ? wdata_raw : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wb_valid    <= 1'b0;
            wb_wd       <= '0;
            wb_wreg     <= 1'b0;
            wb_wdata    <= '0;
            exc_valid   <= 1'b0;
            exc_code    <= '0;
            exc_badaddr <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        wb_valid <= 1'b1;
                        wb_wd    <= ex_wd;
                        wb_wreg  <= ex_wreg & ~fault & ~is_store;
                        wb_wdata <= (is_load & ~fault) ? load_data : ex_result;
                        if (fault) begin
                            state       <= EXC;
                            exc_valid   <= 1'b1;
                            exc_code    <= is_store ? EXC_ADES : EXC_ADEL;
                            exc_badaddr <= ex_addr;
                        end
                    end else if (wb_ready) begin
                        wb_valid <= 1'b0;
                    end
                end
                EXC: begin
                    // Flush: requests are accepted and dropped; only the ack leaves this state.
                    if (wb_ready) wb_valid <= 1'b0;
                    if (exc_ack) begin
                        state     <= RUN;
                        exc_valid <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
